// File: rtl/np_cpl_tracker_pkg.sv
// Shared definitions for the non-posted completion tracker: PCIe-interface
// width defaults, FSM state type, done-FIFO geometry and tag-table entry layout.
`ifndef TAG_NUM_LOG
`define TAG_NUM_LOG 6
`endif
`ifndef DW_LEN_WIDTH
`define DW_LEN_WIDTH 11
`endif
`ifndef TAG_NUM
`define TAG_NUM (1 << `TAG_NUM_LOG)
`endif

package np_cpl_tracker_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } trk_state_t;

  localparam int CHNL_W          = 8;
  localparam int DONE_FIFO_ASIZE = 2;
  localparam int DONE_FIFO_DEPTH = 1 << DONE_FIFO_ASIZE;

  // Tag-table entry layout, MSB to LSB: {live, remaining DW, channel}
  function automatic int entry_width(input int len_w);
    return 1 + len_w + CHNL_W;
  endfunction

endpackage

// File: rtl/np_cpl_tracker_sync_fifo.sv
// pcieifc_sync_fifo: small single-clock show-ahead FIFO with occupancy count.
// rd_data always presents the head entry, so it holds still until popped.
module pcieifc_sync_fifo #(
  parameter int DSIZE = 14,
  parameter int ASIZE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             empty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wr_ptr;
  logic [ASIZE-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (ASIZE+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/np_cpl_tracker.sv
// np_cpl_tracker: per-tag bookkeeping of outstanding non-posted reads.
// Completions are checked against the remaining DW count of their tag in a
// two-stage pipeline; fully completed tags are queued as {tag, channel}.
// Optional build macro NP_CPL_TMO_EN adds a sticky completion-timeout flag.
//
// state   | meaning
// ST_INIT | clearing one table entry per cycle, completions blocked
// ST_RUN  | tracking allocations and completions
module np_cpl_tracker
  import np_cpl_tracker_pkg::*;
#(
  parameter int          TAG_NUM_LOG = `TAG_NUM_LOG,
  parameter int          LEN_W       = `DW_LEN_WIDTH,
  parameter logic [15:0] TMO_CYC     = 16'd50000
) (
  input  logic                   dma_clk,
  input  logic                   dma_rst,
  output logic                   init_done,
  input  logic                   alloc_valid,
  input  logic [TAG_NUM_LOG-1:0] alloc_tag,
  input  logic [LEN_W-1:0]       alloc_sz,
  input  logic [7:0]             alloc_chnl,
  input  logic                   cpl_valid,
  output logic                   cpl_ready,
  input  logic [TAG_NUM_LOG-1:0] cpl_tag,
  input  logic [LEN_W-1:0]       cpl_len,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [TAG_NUM_LOG-1:0] done_tag,
  output logic [7:0]             done_chnl,
  output logic                   cpl_err,
  output logic [TAG_NUM_LOG:0]   outstanding
`ifdef NP_CPL_TMO_EN
  ,
  output logic                   cpl_timeout
`endif
);

  localparam int TAG_NUM = 1 << TAG_NUM_LOG;
  localparam int ENT_W   = entry_width(LEN_W);
  localparam int FIFO_DW = TAG_NUM_LOG + CHNL_W;

  trk_state_t state, state_nxt;
  logic [TAG_NUM_LOG-1:0] init_cnt;
  logic [ENT_W-1:0]       tbl [TAG_NUM];

  logic run, alloc_en, cpl_acc;

  logic                   s1_valid;
  logic [TAG_NUM_LOG-1:0] s1_tag;
  logic [LEN_W-1:0]       s1_len;
  logic [ENT_W-1:0]       s1_ent;
  logic [ENT_W-1:0]       rd_ent;

  logic                   s1_live;
  logic [LEN_W-1:0]       s1_rem;
  logic [CHNL_W-1:0]      s1_chnl;
  logic                   s2_illegal;
  logic [LEN_W-1:0]       s2_rem_nxt;
  logic                   s2_wr;
  logic                   s2_release;

  logic                   fifo_full, fifo_empty;
  logic [DONE_FIFO_ASIZE:0] fifo_cnt;
  logic [FIFO_DW-1:0]     fifo_rd;
  logic [DONE_FIFO_ASIZE+1:0] fifo_resv;

  assign run      = (state == ST_RUN);
  assign alloc_en = alloc_valid & run;
  assign cpl_acc  = cpl_valid & cpl_ready;

  // A completion in stage 1 may still push, so it reserves a FIFO slot
  assign fifo_resv = {1'b0, fifo_cnt} + {{(DONE_FIFO_ASIZE+1){1'b0}}, s1_valid};
  assign cpl_ready = run & ~fifo_full & (fifo_resv < (DONE_FIFO_ASIZE+2)'(DONE_FIFO_DEPTH));
  assign init_done = run;

  // State register
  always_ff @(posedge dma_clk) begin
    if (dma_rst) state <= ST_INIT;
    else         state <= state_nxt;
  end

  // Next state: leave INIT after the last entry is cleared
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (&init_cnt) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Table clear index
  always_ff @(posedge dma_clk) begin
    if (dma_rst)              init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  // Stage 2: check the completion against the entry read in stage 1
  always_comb begin
    s1_live    = s1_ent[ENT_W-1];
    s1_rem     = s1_ent[CHNL_W +: LEN_W];
    s1_chnl    = s1_ent[CHNL_W-1:0];
    s2_illegal = ~s1_live | (s1_len > s1_rem) | (s1_len == '0);
    s2_rem_nxt = s1_rem - s1_len;
    s2_wr      = s1_valid & ~s2_illegal;
    s2_release = s2_wr & (s2_rem_nxt == '0);
  end

  // Stage 1 read with forwarding: same-cycle alloc, then stage-2 result
  always_comb begin
    rd_ent = tbl[cpl_tag];
    if (s2_wr && (s1_tag == cpl_tag))
      rd_ent = {~s2_release, s2_rem_nxt, s1_chnl};
    if (alloc_en && (alloc_tag == cpl_tag))
      rd_ent = {1'b1, alloc_sz, alloc_chnl};
  end

  // Tag table: init clear, stage-2 update, alloc last so it wins on a tag clash
  always_ff @(posedge dma_clk) begin
    if (state == ST_INIT) begin
      tbl[init_cnt] <= '0;
    end else begin
      if (s2_wr)    tbl[s1_tag]    <= {~s2_release, s2_rem_nxt, s1_chnl};
      if (alloc_en) tbl[alloc_tag] <= {1'b1, alloc_sz, alloc_chnl};
    end
  end

  // Stage-1 pipeline register
  always_ff @(posedge dma_clk) begin
    if (dma_rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= cpl_acc;
      if (cpl_acc) begin
        s1_tag <= cpl_tag;
        s1_len <= cpl_len;
        s1_ent <= rd_ent;
      end
    end
  end

  // Illegal-completion pulse
  always_ff @(posedge dma_clk) begin
    if (dma_rst) cpl_err <= 1'b0;
    else         cpl_err <= s1_valid & s2_illegal;
  end

  // Live-tag count; a simultaneous grant and release cancel out
  always_ff @(posedge dma_clk) begin
    if (dma_rst) begin
      outstanding <= '0;
    end else begin
      case ({alloc_en, s2_release})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  pcieifc_sync_fifo #(
    .DSIZE (FIFO_DW),
    .ASIZE (DONE_FIFO_ASIZE)
  ) u_done_fifo (
    .clk     (dma_clk),
    .rst     (dma_rst),
    .wr_en   (s2_release),
    .wr_data ({s1_tag, s1_chnl}),
    .full    (fifo_full),
    .rd_en   (done_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign done_valid = ~fifo_empty;
  assign done_tag   = fifo_rd[FIFO_DW-1:CHNL_W];
  assign done_chnl  = fifo_rd[CHNL_W-1:0];

`ifdef NP_CPL_TMO_EN
  logic [15:0] tmo_cnt, tmo_nxt;

  // Idle-wait counter: restarts on progress or when nothing is outstanding
  always_comb begin
    tmo_nxt = tmo_cnt;
    if (cpl_acc || (outstanding == '0)) tmo_nxt = '0;
    else if (tmo_cnt != TMO_CYC)         tmo_nxt = tmo_cnt + 16'd1;
  end

  // Counter register and sticky timeout flag
  always_ff @(posedge dma_clk) begin
    if (dma_rst) begin
      tmo_cnt     <= '0;
      cpl_timeout <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      if (tmo_nxt == TMO_CYC) cpl_timeout <= 1'b1;
    end
  end
`else
  // Threshold has no consumer without the timeout logic
  logic tmo_unused;
  assign tmo_unused = ^TMO_CYC;
`endif

endmodule

// File: doc/np_cpl_tracker.md
NP_CPL_TRACKER -- requirements
Module: np_cpl_tracker

Interface
REQ-001 Parameter TAG_NUM_LOG, default `TAG_NUM_LOG (6), width of tag index; table depth 2**TAG_NUM_LOG.
REQ-002 Parameter LEN_W, default `DW_LEN_WIDTH, width of DW length and remaining-count fields.
REQ-003 Parameter TMO_CYC, default 16'd50000, completion-timeout threshold in dma_clk cycles.
REQ-004 dma_clk  in  1  sole clock; all logic on the rising edge.
REQ-005 dma_rst  in  1  synchronous, active-high reset.
REQ-006 init_done  out  1  high once the tag table is cleared.
REQ-007 alloc_valid  in  1  a tag was granted to a non-posted read this cycle; no ready, always accepted.
REQ-008 alloc_tag / alloc_sz / alloc_chnl  in  TAG_NUM_LOG / LEN_W / 8  granted tag, requested DW, channel.
REQ-009 cpl_valid / cpl_ready  in / out  1 / 1  completion-header handshake.
REQ-010 cpl_tag / cpl_len  in  TAG_NUM_LOG / LEN_W  tag and DW payload length of the completion.
REQ-011 done_valid / done_ready  out / in  1 / 1  tag-fully-completed handshake.
REQ-012 done_tag / done_chnl  out  TAG_NUM_LOG / 8  completed tag and its owning channel.
REQ-013 cpl_err  out  1  one-cycle pulse on an illegal completion.
REQ-014 outstanding  out  TAG_NUM_LOG+1  count of live tags.
REQ-015 cpl_timeout  out  1  sticky timeout flag (present only with NP_CPL_TMO_EN).

Function
REQ-016 States: INIT (clear entry init_cnt, 1 per cycle, 2**TAG_NUM_LOG cycles) -> RUN; no other transitions except reset.
REQ-017 Table entry per tag: live bit, remaining DW (LEN_W), chnl (8).
REQ-018 cpl_ready = RUN & done-FIFO not full; alloc_valid in INIT is ignored.
REQ-019 alloc in RUN: entry <= {live=1, rem=alloc_sz, chnl=alloc_chnl}; outstanding+1.
REQ-020 Accepted completion, stage 1 reads entry; stage 2 writes rem-cpl_len.
REQ-021 Illegal (entry not live, or cpl_len > rem, or cpl_len == 0): entry unchanged, cpl_err pulses in stage 2, nothing emitted.
REQ-022 rem-cpl_len == 0: live<=0, outstanding-1, {tag,chnl} pushed to 4-entry done FIFO; done_valid = FIFO not empty.
REQ-023 Latency: cpl accepted cycle N -> done_valid high at N+2 with an empty FIFO.
REQ-024 Back-to-back completions to same tag: stage-2 result bypassed into stage-1 read; no stale remaining count.
REQ-025 alloc and stage-2 write to same tag in same cycle: alloc wins (released tag re-granted); distinct tags both take effect.
REQ-026 Simultaneous alloc and release: outstanding unchanged.
REQ-027 Arithmetic LEN_W bits, no wrap: underflow excluded by REQ-021.
REQ-028 done_tag/done_chnl stable while done_valid & !done_ready.

Reset
REQ-029 dma_rst: state INIT, init_cnt 0, init_done 0, cpl_ready 0, done_valid 0, cpl_err 0, outstanding 0, cpl_timeout 0, pipeline and FIFO emptied.
REQ-030 Reset mid-operation discards all in-flight completions and done entries; table re-cleared.

Configuration
REQ-031 NP_CPL_TMO_EN defined: counter clears on each accepted completion or when outstanding == 0, else increments; reaching TMO_CYC sets cpl_timeout until reset.
REQ-032 NP_CPL_TMO_EN undefined: counter and cpl_timeout port absent; no other change.

Structure
REQ-033 TAG_NUM_LOG, DW_LEN_WIDTH, TAG_NUM come from the shared PCIe-interface define header; table entry layout is a shared constant there.
REQ-034 Done FIFO is the existing pcieifc_sync_fifo sub-module (DSIZE TAG_NUM_LOG+8, ASIZE 2); table is inferred register/RAM.

Verification
REQ-035 Reset release -> init_done rises after 64 cycles; cpl_ready 0 before.
REQ-036 alloc tag 5 sz 32 chnl 3; cpl tag 5 len 16, then len 16 back-to-back -> one done {5,3} at second accept+2; outstanding 1->0.
REQ-037 cpl tag 9 unallocated -> cpl_err one pulse, no done, outstanding unchanged.
REQ-038 alloc tag 2 sz 8; cpl tag 2 len 12 -> cpl_err, entry still rem 8; then len 8 -> done {2,chnl}.
REQ-039 done_ready 0, 5 tags complete -> 4 buffered, cpl_ready drops, resumes after done_ready 1, no loss or reorder.
REQ-040 NP_CPL_TMO_EN, TMO_CYC 100, one live tag, no completions -> cpl_timeout at cycle 100 and held.
